nibble_add_sched: RTL and testbench

Multi-cycle, nibble-serial adder engine shared between two requesters. It sequences a single 4-bit full-adder slice across NIBBLES nibbles, LSB nibble first, and chains the carry through a register. Fair round-robin arbitration picks which requester's operands are captured. It sits between two client blocks that need occasional wide additions and a single small adder datapath, and trades latency for area.

---
 rtl/nibble_add_sched.sv | 182 ++++++++++++++++++
 tb/tb_nibble_add_sched.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_add_sched.sv
// -----------------------------------------------------------------------------
// nibble_add_sched
//
// Nibble-serial adder shared by two requesters. One 4-bit adder slice walks
// over the operands LSB nibble first. The carry between nibbles is held in a
// register. When both requesters are waiting, a round-robin pointer picks which
// one's operands are captured.
//
// Ports:
//   clk            single clock, rising edge
//   rst            asynchronous active-high reset
//   req0/req1      level-sensitive requests
//   a0,b0,cin0     requester 0 operands and carry-in (stable while req0 high)
//   a1,b1,cin1     requester 1 operands and carry-in (stable while req1 high)
//   gnt0/gnt1      one-cycle pulse: that requester's operands were captured
//   busy           high while an addition is in progress
//   done           one-cycle pulse: sum/done_id hold a new result
//   done_id        requester that owns the current sum
//   sum            W+1 bit result, bit W is the final carry-out
// -----------------------------------------------------------------------------
module nibble_add_sched #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0,
    input  logic [4*NIBBLES-1:0]   a0,
    input  logic [4*NIBBLES-1:0]   b0,
    input  logic                   cin0,
    input  logic                   req1,
    input  logic [4*NIBBLES-1:0]   a1,
    input  logic [4*NIBBLES-1:0]   b1,
    input  logic                   cin1,
    output logic                   gnt0,
    output logic                   gnt1,
    output logic                   busy,
    output logic                   done,
    output logic                   done_id,
    output logic [4*NIBBLES:0]     sum
);

    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ADD  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic [W-1:0]      r_acc;
    logic              r_carry;
    logic [IDXW-1:0]   r_idx;
    logic              r_last;
    logic              r_owner;

    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_busy;
    logic              r_done;
    logic              r_done_id;
    logic [W:0]        r_sum;

    logic              w_pick1;
    logic              w_capture;
    logic              w_grant_id;
    logic              w_last_nib;
    logic [3:0]        w_a_nib;
    logic [3:0]        w_b_nib;
    logic [4:0]        w_nib_add;
    logic [W-1:0]      w_acc_next;

    // Round-robin choice: on a tie grant the requester not served last time.
    assign w_pick1 = req1 & (~req0 | ~r_last);

    // Next-state and control decode for the IDLE/ADD sequencer.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_grant_id   = 1'b0;
        w_last_nib   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req0 | req1) begin
                    w_capture    = 1'b1;
                    w_grant_id   = w_pick1;
                    w_state_next = ST_ADD;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ADD: begin
                if (r_idx == LAST_IDX) begin
                    w_last_nib   = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_ADD;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Shared 4-bit adder slice plus accumulator with the current nibble merged in.
    always_comb begin
        w_a_nib    = r_a[int'(r_idx) * 4 +: 4];
        w_b_nib    = r_b[int'(r_idx) * 4 +: 4];
        w_nib_add  = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'd0, r_carry};
        w_acc_next = r_acc;
        w_acc_next[int'(r_idx) * 4 +: 4] = w_nib_add[3:0];
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand capture, nibble walk and round-robin bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_last  <= 1'b1;
            r_owner <= 1'b0;
        end else if (w_capture) begin
            r_a     <= w_grant_id ? a1 : a0;
            r_b     <= w_grant_id ? b1 : b0;
            r_carry <= w_grant_id ? cin1 : cin0;
            r_acc   <= '0;
            r_idx   <= '0;
            r_last  <= w_grant_id;
            r_owner <= w_grant_id;
        end else if (r_state == ST_ADD) begin
            r_acc   <= w_acc_next;
            r_carry <= w_nib_add[4];
            r_idx   <= w_last_nib ? '0 : r_idx + IDXW'(1);
        end
    end

    // Registered outputs; sum/done_id only move on the final nibble edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= 1'b0;
            r_sum     <= '0;
        end else begin
            r_gnt0 <= w_capture & ~w_grant_id;
            r_gnt1 <= w_capture & w_grant_id;
            r_busy <= (w_state_next == ST_ADD);
            r_done <= w_last_nib;
            if (w_last_nib) begin
                r_sum     <= {w_nib_add[4], w_acc_next};
                r_done_id <= r_owner;
            end
        end
    end

    assign gnt0    = r_gnt0;
    assign gnt1    = r_gnt1;
    assign busy    = r_busy;
    assign done    = r_done;
    assign done_id = r_done_id;
    assign sum     = r_sum;

endmodule

// File: tb/tb_nibble_add_sched.sv
// -----------------------------------------------------------------------------
// tb_nibble_add_sched
//
// Directed bench for nibble_add_sched with NIBBLES=4. Expected sums are
// hand-computed constants; outputs are sampled 1 time unit after each rising
// edge.
// -----------------------------------------------------------------------------
module tb_nibble_add_sched;

    logic        clk;
    logic        rst;
    logic        req0;
    logic [15:0] a0;
    logic [15:0] b0;
    logic        cin0;
    logic        req1;
    logic [15:0] a1;
    logic [15:0] b1;
    logic        cin1;
    logic        gnt0;
    logic        gnt1;
    logic        busy;
    logic        done;
    logic        done_id;
    logic [16:0] sum;

    int n_checks;
    int n_errors;

    nibble_add_sched #(.NIBBLES(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .a0      (a0),
        .b0      (b0),
        .cin0    (cin0),
        .req1    (req1),
        .a1      (a1),
        .b1      (b1),
        .cin1    (cin1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .sum     (sum)
    );

    // 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation for a single requester with the full timing checked.
    task automatic run_op(input string tag, input logic id, input logic [15:0] a,
                          input logic [15:0] b, input logic c, input logic [16:0] exp);
        if (id == 1'b0) begin
            a0 = a; b0 = b; cin0 = c; req0 = 1'b1;
        end else begin
            a1 = a; b1 = b; cin1 = c; req1 = 1'b1;
        end
        tick();
        check_val({tag, ".gnt_own"}, {31'd0, (id == 1'b0) ? gnt0 : gnt1}, 32'd1);
        check_val({tag, ".gnt_oth"}, {31'd0, (id == 1'b0) ? gnt1 : gnt0}, 32'd0);
        check_val({tag, ".busy0"},   {31'd0, busy}, 32'd1);
        check_val({tag, ".done0"},   {31'd0, done}, 32'd0);
        req0 = 1'b0;
        req1 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k < 4) begin
                check_val({tag, ".busy"}, {31'd0, busy}, 32'd1);
                check_val({tag, ".done_early"}, {31'd0, done}, 32'd0);
                check_val({tag, ".gnt_pulse"}, {30'd0, gnt1, gnt0}, 32'd0);
            end else begin
                check_val({tag, ".done"},    {31'd0, done}, 32'd1);
                check_val({tag, ".busy_end"},{31'd0, busy}, 32'd0);
                check_val({tag, ".sum"},     {15'd0, sum}, {15'd0, exp});
                check_val({tag, ".done_id"}, {31'd0, done_id}, {31'd0, id});
            end
        end
        tick();
        check_val({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    // Reset pulse with reset-value checks while rst is high.
    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        check_val("rst.gnt",     {30'd0, gnt1, gnt0}, 32'd0);
        check_val("rst.busy",    {31'd0, busy}, 32'd0);
        check_val("rst.done",    {31'd0, done}, 32'd0);
        check_val("rst.done_id", {31'd0, done_id}, 32'd0);
        check_val("rst.sum",     {15'd0, sum}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [16:0] prev_sum;
    logic [16:0] exp_f;

    // Main directed sequence.
    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        req0 = 1'b0; a0 = 16'h0000; b0 = 16'h0000; cin0 = 1'b0;
        req1 = 1'b0; a1 = 16'h0000; b1 = 16'h0000; cin1 = 1'b0;
        do_reset();

        // Basic add and carry-ripple cases.
        run_op("basic", 1'b0, 16'h1234, 16'h4321, 1'b0, 17'h05555);
        run_op("ripple", 1'b1, 16'hFFFF, 16'h0001, 1'b0, 17'h10000);
        run_op("cin", 1'b1, 16'h000F, 16'h0000, 1'b1, 17'h00010);

        // Tie after reset: requester 0 first, requester 1 follows right after done.
        do_reset();
        a0 = 16'h8000; b0 = 16'h8000; cin0 = 1'b1;
        a1 = 16'h0001; b1 = 16'h0002; cin1 = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        tick();
        check_val("tie.gnt0", {31'd0, gnt0}, 32'd1);
        check_val("tie.gnt1", {31'd0, gnt1}, 32'd0);
        req0 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k < 4) begin
                check_val("tie.no_gnt", {30'd0, gnt1, gnt0}, 32'd0);
            end
        end
        check_val("tie.done1", {31'd0, done}, 32'd1);
        check_val("tie.sum1",  {15'd0, sum}, 32'h00010001);
        check_val("tie.id1",   {31'd0, done_id}, 32'd0);
        tick();
        check_val("tie.gnt1b", {31'd0, gnt1}, 32'd1);
        check_val("tie.done_low", {31'd0, done}, 32'd0);
        req1 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
        end
        check_val("tie.done2", {31'd0, done}, 32'd1);
        check_val("tie.sum2",  {15'd0, sum}, 32'h00000003);
        check_val("tie.id2",   {31'd0, done_id}, 32'd1);
        tick();

        // Fairness: both requests held for six operations.
        do_reset();
        a0 = 16'h1111; b0 = 16'h2222; cin0 = 1'b0;
        a1 = 16'hABCD; b1 = 16'h5433; cin1 = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        prev_sum = 17'h00000;
        for (int j = 0; j < 6; j++) begin
            tick();
            check_val("fair.gnt", {30'd0, gnt1, gnt0}, (j % 2 == 0) ? 32'd1 : 32'd2);
            exp_f = (j % 2 == 0) ? 17'h03333 : 17'h10001;
            for (int k = 1; k <= 4; k++) begin
                tick();
                if (k < 4) begin
                    check_val("fair.stable", {15'd0, sum}, {15'd0, prev_sum});
                    check_val("fair.no_done", {31'd0, done}, 32'd0);
                end else begin
                    check_val("fair.done", {31'd0, done}, 32'd1);
                    check_val("fair.sum", {15'd0, sum}, {15'd0, exp_f});
                    check_val("fair.id", {31'd0, done_id}, (j % 2 == 0) ? 32'd0 : 32'd1);
                end
            end
            prev_sum = exp_f;
            if (j == 5) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        tick();
        check_val("fair.idle", {31'd0, busy}, 32'd0);

        // req1 pulsed wholly inside a requester-0 addition is ignored.
        a0 = 16'h0F0F; b0 = 16'h00F1; cin0 = 1'b0;
        a1 = 16'h7777; b1 = 16'h1111; cin1 = 1'b1;
        req0 = 1'b1;
        tick();
        check_val("ign.gnt0", {31'd0, gnt0}, 32'd1);
        req0 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) req1 = 1'b1;
            if (k == 3) req1 = 1'b0;
            check_val("ign.gnt1", {31'd0, gnt1}, 32'd0);
        end
        check_val("ign.done", {31'd0, done}, 32'd1);
        check_val("ign.sum",  {15'd0, sum}, 32'h00001000);
        check_val("ign.id",   {31'd0, done_id}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val("ign.no_extra", {29'd0, done, gnt1, busy}, 32'd0);
        end

        // Reset two edges after capture aborts the addition.
        a0 = 16'h0101; b0 = 16'h0202; cin0 = 1'b0;
        req0 = 1'b1;
        tick();
        req0 = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_val("mid.busy", {31'd0, busy}, 32'd0);
        check_val("mid.gnt",  {30'd0, gnt1, gnt0}, 32'd0);
        check_val("mid.done", {31'd0, done}, 32'd0);
        check_val("mid.sum",  {15'd0, sum}, 32'd0);
        tick();
        check_val("mid.sum_hold", {15'd0, sum}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        a0 = 16'h0A0A; b0 = 16'h0505; cin0 = 1'b1;
        a1 = 16'h1111; b1 = 16'h1111; cin1 = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        tick();
        check_val("post.gnt", {30'd0, gnt1, gnt0}, 32'd1);
        req0 = 1'b0; req1 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
        end
        check_val("post.done", {31'd0, done}, 32'd1);
        check_val("post.sum",  {15'd0, sum}, 32'h00000F10);
        check_val("post.id",   {31'd0, done_id}, 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout got 0x0 expected 0x1");
        $fatal(1, "time limit");
    end

endmodule
